// File: rtl/backbone_pkg.sv
// Shared backbone types and constants: stream word width, conv1 stream lengths,
// and the tensor streamer FSM encoding.
package backbone_pkg;

  localparam int unsigned DATA_W = 32;

  localparam int unsigned CONV1_FMAP_TOT   = 37632;
  localparam int unsigned CONV1_WEIGHT_TOT = 9408;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StFinish
  } streamer_state_t;

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry FIFO with a registered head slot; push and pop may coincide, including when full.
// Entry 0 is always the head, so the output comes straight from a flop.
module axis_skid_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem_q [2];
  logic [1:0]       count_q;
  logic             do_pop;
  logic             do_push;
  logic [1:0]       wr_idx;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);
  // Slot the new word lands in once any pop has shifted entry 1 forward.
  assign wr_idx  = count_q - {1'b0, do_pop};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= 2'd0;
    end else begin
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
      if (do_pop) begin
        mem_q[0] <= mem_q[1];
      end
      if (do_push) begin
        mem_q[wr_idx[0]] <= push_data_i;
      end
    end
  end

  assign head_o  = mem_q[0];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/axis_tensor_streamer.sv
// Memory-to-AXI-Stream transmitter: streams `length` SRAM words from `base_addr` as one packet.
// Define STREAMER_PERF_CNT_EN to build the backpressure stall counter on stall_cycles.
module axis_tensor_streamer #(
  parameter int unsigned DATA_W = backbone_pkg::DATA_W,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [31:0]       stall_cycles
);

  import backbone_pkg::*;

  streamer_state_t   state_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  sent_q;
  logic              busy_q;
  logic              done_q;
  logic              inflight_q;
  logic              inflight_last_q;

  logic [1:0]        fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_head;
  logic              pop;
  logic              rd_en;
  logic              last_issue;
  logic [2:0]        occ_after_pop;

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_head[DATA_W-1:0];
  assign m_axis_tlast  = fifo_head[DATA_W];
  assign pop           = m_axis_tvalid && m_axis_tready;

  // Credit the slot being popped this cycle so steady tready=1 sustains one beat per cycle.
  assign occ_after_pop = 3'(fifo_count) - 3'(pop) + 3'(inflight_q);
  assign rd_en         = (state_q == StStream) && (issued_q < len_q) && (occ_after_pop < 3'd2);
  assign last_issue    = (issued_q == len_q - LEN_W'(1));

  assign mem_rd_en   = rd_en;
  assign mem_rd_addr = base_q + ADDR_W'(issued_q);
  assign busy        = busy_q;
  assign done        = done_q;

  axis_skid_fifo2 #(
    .Width(DATA_W + 1)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_data_i({inflight_last_q, mem_rd_data}),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      base_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      sent_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      // Read data returns one cycle after the strobe; track it so it can be pushed on arrival.
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en && last_issue;
      if (rd_en) begin
        issued_q <= issued_q + LEN_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            base_q   <= base_addr;
            len_q    <= length;
            issued_q <= '0;
            sent_q   <= '0;
            if (length == '0) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end else begin
              state_q <= StStream;
              busy_q  <= 1'b1;
            end
          end
        end
        StStream: begin
          if (pop) begin
            sent_q <= sent_q + LEN_W'(1);
            if (sent_q == len_q - LEN_W'(1)) begin
              state_q <= StFinish;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StFinish: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read credits guarantee a returning word always finds a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight_q && fifo_full && !pop));

`ifdef STREAMER_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      stall_q <= '0;
    end else if (busy_q && m_axis_tvalid && !m_axis_tready && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/axis_tensor_streamer.md
Name: axis_tensor_streamer

Overview:
- Memory-to-AXI-Stream transmitter that feeds the conv1 accelerator's s_axis_fmap and s_axis_weight inputs.
- On start, reads `length` consecutive words from a 1-cycle-latency on-chip SRAM beginning at `base_addr`, and emits them as one AXIS packet with tlast on the final beat.
- Honours backpressure without losing or duplicating words.
- One instance per input stream (fmap: length 37632; weight: length 9408).

Parameters:
- DATA_W, backbone_pkg::DATA_W, stream/SRAM word width.
- ADDR_W, 16, SRAM word-address width.
- LEN_W, 18, width of the packet length field (max 2^LEN_W-1 words).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  launch request; sampled only in IDLE
- base_addr  in  ADDR_W  first SRAM word address; latched on accepted start
- length  in  LEN_W  number of beats; latched on accepted start
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle pulse after the final handshake
- mem_rd_en  out  1  SRAM read strobe
- mem_rd_addr  out  ADDR_W  SRAM read address
- mem_rd_data  in  DATA_W  SRAM data; valid the cycle after mem_rd_en
- m_axis_tvalid  out  1  AXIS valid
- m_axis_tready  in  1  AXIS ready
- m_axis_tdata  out  DATA_W  AXIS data
- m_axis_tlast  out  1  high on beat index length-1
- stall_cycles  out  32  backpressure counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge) clears all state: busy=0, done=0, mem_rd_en=0, mem_rd_addr=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, stall_cycles=0.
- Reset mid-transfer aborts the transfer. In-flight read data is discarded and no further beats are emitted.
- FSM has three states: IDLE, STREAM, FINISH.
  - IDLE -> STREAM on start=1 at a posedge. base_addr and length are latched; issued and sent counters are cleared; busy=1 from the next cycle.
  - IDLE with start=1 and length=0 -> FINISH directly. No read is issued and no beat is emitted.
  - STREAM -> FINISH on the handshake (tvalid&tready) of beat length-1.
  - FINISH -> IDLE after one cycle. done=1 and busy=0 during that cycle.
  - start while busy or in FINISH is ignored.
- Read issue:
  - mem_rd_en=1 when issued<length and (buffer occupancy + reads in flight) < 2.
  - mem_rd_addr = base_addr + issued.
  - Address wraps modulo 2^ADDR_W, with no error.
- Buffering: read data lands in a 2-entry FIFO. The head drives tdata/tlast.
  - tvalid = FIFO not empty.
  - tdata and tlast are held stable while tvalid=1 and tready=0.
- Latency: start sampled at edge T -> mem_rd_en high during cycle T+1 -> tvalid high after edge T+2.
- Throughput: 1 beat/cycle sustained while tready=1.
- Simultaneous FIFO push and pop when full is legal; occupancy stays 2.
- tready toggling every cycle: no drop or duplicate. Beat order equals address order.
- tlast is asserted only on the beat with sent==length-1. length=1 gives a single beat with tlast=1.
- done never coincides with tvalid=1.

Optional Feature:
- Macro STREAMER_PERF_CNT_EN.
- Defined: stall_cycles increments every cycle with busy&tvalid&!tready. It is cleared on an accepted start, holds its value after done, and saturates at 2^32-1.
- Undefined: stall_cycles is tied to 0 and no counter logic is synthesized.

Decomposition:
- backbone_pkg additions:
  - streamer_state_t enum (IDLE, STREAM, FINISH).
  - Constants CONV1_FMAP_TOT=37632 and CONV1_WEIGHT_TOT=9408.
- Sub-module axis_skid_fifo2: 2-entry, registered-output FIFO with push/pop, full/empty and count outputs. It is reusable for the output-side sink.

Test Plan:
- Basic stream: base=0x0100, length=8, SRAM[a]=a&0xFF, tready=1 -> beats 0x00..0x07 on consecutive cycles; tlast only on beat 7; done one cycle after beat 7; first tvalid at T+2.
- Backpressure: length=16, tready pattern 1,0,0,1 repeating -> all 16 words in order, none dropped or duplicated, tdata stable during stalls; stall_cycles=expected stall count with STREAMER_PERF_CNT_EN.
- Edge lengths: length=0 -> done pulse one cycle after start, zero beats, mem_rd_en never high; length=1 -> single beat with tlast=1.
- Address wrap: ADDR_W=16, base=0xFFFE, length=4 -> reads 0xFFFE, 0xFFFF, 0x0000, 0x0001 in order.
- Reset/abort: rst_n=0 for one cycle after beat 5 of 20 -> all outputs 0 next cycle; a new start with length=3 then streams correctly with no stale data; start pulsed while busy is ignored.
- Conv1 integration: fmap instance length 37632 and weight instance length 9408 drive conv1_axi_stream_top -> 200704 outputs match the golden data with zero errors.
